// File: rtl/conv_pkg.sv
// Shared types and constants for the conv loop-nest sequencer.
// Optional cycle counters are enabled with CONV_LOOP_CTRL_PERF_EN.
package conv_pkg;

    localparam int unsigned PARAM_NUM       = 6;
    localparam int unsigned PARAM_WID       = 16;
    localparam int unsigned BANK_ADDR_WIDTH = 32;
    localparam int unsigned PERF_WIDTH      = 32;

    // Intra-tile nest, innermost first: ox0, oy0, fx, fy, ic1
    localparam int unsigned STEP_LEVELS = 5;
    // Tile nest, innermost first: oc1, ox1, oy1
    localparam int unsigned TILE_LEVELS = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RUN,
        TILE_END
    } state_t;

    // Field order matches the packed word; oy1 occupies the MSBs
    typedef struct packed {
        logic [PARAM_WID-1:0] oy1;
        logic [PARAM_WID-1:0] oc1;
        logic [PARAM_WID-1:0] ic1;
        logic [PARAM_WID-1:0] fy;
        logic [PARAM_WID-1:0] oy0;
        logic [PARAM_WID-1:0] stride;
    } params_t;

    function automatic logic params_bad(input params_t p);
        return (p.oy1 == '0) || (p.oc1 == '0) || (p.ic1 == '0) ||
               (p.fy == '0) || (p.oy0 == '0) || (p.stride == '0);
    endfunction

endpackage

// File: rtl/conv_loop_ctrl_if.sv
// Parameter handshake, bank status and MAC-step bus of the conv loop sequencer.
// Carries the cycle counters only when CONV_LOOP_CTRL_PERF_EN is defined.
interface conv_loop_ctrl_if;
    import conv_pkg::*;

    logic [PARAM_NUM*PARAM_WID-1:0] layer_params_dat;
    logic                           layer_params_vld;
    logic                           layer_params_rdy;
    logic                           ifmap_bank_ready;
    logic                           weights_bank_ready;
    logic                           ofmap_bank_free;
    logic [BANK_ADDR_WIDTH-1:0]     ifmap_rd_addr;
    logic [BANK_ADDR_WIDTH-1:0]     weights_rd_addr;
    logic [BANK_ADDR_WIDTH-1:0]     ofmap_wr_addr;
    logic                           step_vld;
    logic                           acc_first;
    logic                           acc_last;
    logic                           ifmap_switch;
    logic                           weights_switch;
    logic                           ofmap_switch;
    logic                           layer_done;
    logic                           params_err;
`ifdef CONV_LOOP_CTRL_PERF_EN
    logic [PERF_WIDTH-1:0]          stall_cycles;
    logic [PERF_WIDTH-1:0]          busy_cycles;
`endif

    modport master (
        output layer_params_dat, layer_params_vld,
               ifmap_bank_ready, weights_bank_ready, ofmap_bank_free,
        input  layer_params_rdy, ifmap_rd_addr, weights_rd_addr, ofmap_wr_addr,
               step_vld, acc_first, acc_last,
               ifmap_switch, weights_switch, ofmap_switch, layer_done, params_err
`ifdef CONV_LOOP_CTRL_PERF_EN
        , input stall_cycles, busy_cycles
`endif
    );

    modport slave (
        input  layer_params_dat, layer_params_vld,
               ifmap_bank_ready, weights_bank_ready, ofmap_bank_free,
        output layer_params_rdy, ifmap_rd_addr, weights_rd_addr, ofmap_wr_addr,
               step_vld, acc_first, acc_last,
               ifmap_switch, weights_switch, ofmap_switch, layer_done, params_err
`ifdef CONV_LOOP_CTRL_PERF_EN
        , output stall_cycles, busy_cycles
`endif
    );

endinterface

// File: rtl/conv_loop_counter.sv
// Nested wrap counter: level 0 is innermost; each level counts 0..bound-1
// and advances when inc is set and every inner level sits at its maximum.
module conv_loop_counter #(
    parameter int unsigned LEVELS = 1,
    parameter int unsigned WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         inc,
    input  logic [LEVELS-1:0][WIDTH-1:0] bound,
    output logic [LEVELS-1:0][WIDTH-1:0] cnt
);

    logic [LEVELS-1:0] at_max;
    logic [LEVELS-1:0] step;

    always_comb begin : carry_chain
        logic carry;
        carry  = inc;
        at_max = '0;
        step   = '0;
        for (int i = 0; i < int'(LEVELS); i++) begin
            at_max[i] = (cnt[i] == bound[i] - WIDTH'(1));
            step[i]   = carry;
            carry     = carry & at_max[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < int'(LEVELS); i++) begin
                if (step[i]) cnt[i] <= at_max[i] ? '0 : cnt[i] + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/conv_loop_ctrl.sv
// Loop-nest sequencer for the tiled conv datapath: one MAC step per cycle.
// Define CONV_LOOP_CTRL_PERF_EN to add the stall/busy cycle counters.
module conv_loop_ctrl
    import conv_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    conv_loop_ctrl_if.slave bus
);

    localparam int unsigned AW = BANK_ADDR_WIDTH;
    localparam int unsigned PW = PARAM_WID;

    state_t  state, state_next;
    params_t prm_in, prm;
    logic    bad_c, accept_c, issue, tile_adv;

    logic [AW-1:0] ix0, ixy, ix0_in, ixy_in;

    logic [STEP_LEVELS-1:0][PW-1:0] step_bound, step_cnt;
    logic [TILE_LEVELS-1:0][PW-1:0] tile_bound, tile_cnt;
    logic [STEP_LEVELS-1:0]         step_max;
    logic [TILE_LEVELS-1:0]         tile_max;

    logic [AW-1:0] ifmap_addr_c, weights_addr_c, ofmap_addr_c;
    logic [AW-1:0] ox0, oy0, fx, fy, ic1, stride, fy_b, oy0_b;
    logic          first_c, last_c;

    logic          rdy_q, err_q, step_vld_q, first_q, last_q, tile_last_q;
    logic          isw_q, wsw_q, osw_q, done_q;
    logic [AW-1:0] ifmap_addr_q, weights_addr_q, ofmap_addr_q;

    assign prm_in   = params_t'(bus.layer_params_dat);
    assign bad_c    = params_bad(prm_in);
    assign accept_c = (state == IDLE) && bus.layer_params_vld && rdy_q && !bad_c;

    // Square tiles and filters: IX0 == IY0, so the plane size is IX0^2
    assign ix0_in = (AW'(prm_in.oy0) - AW'(1)) * AW'(prm_in.stride) + AW'(prm_in.fy);
    assign ixy_in = ix0_in * ix0_in;

    assign step_bound = {prm.ic1, prm.fy, prm.fy, prm.oy0, prm.oy0};
    assign tile_bound = {prm.oy1, prm.oy1, prm.oc1};

    conv_loop_counter #(.LEVELS(STEP_LEVELS), .WIDTH(PW)) u_step_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_c),
        .inc   (issue),
        .bound (step_bound),
        .cnt   (step_cnt)
    );

    conv_loop_counter #(.LEVELS(TILE_LEVELS), .WIDTH(PW)) u_tile_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_c),
        .inc   (tile_adv),
        .bound (tile_bound),
        .cnt   (tile_cnt)
    );

    always_comb begin
        step_max = '0;
        tile_max = '0;
        for (int i = 0; i < int'(STEP_LEVELS); i++)
            step_max[i] = (step_cnt[i] == step_bound[i] - PW'(1));
        for (int i = 0; i < int'(TILE_LEVELS); i++)
            tile_max[i] = (tile_cnt[i] == tile_bound[i] - PW'(1));
    end

    // Address generation for the step currently held in the counters
    always_comb begin
        ox0    = AW'(step_cnt[0]);
        oy0    = AW'(step_cnt[1]);
        fx     = AW'(step_cnt[2]);
        fy     = AW'(step_cnt[3]);
        ic1    = AW'(step_cnt[4]);
        stride = AW'(prm.stride);
        fy_b   = AW'(prm.fy);
        oy0_b  = AW'(prm.oy0);
        ifmap_addr_c   = ic1 * ixy + (oy0 * stride + fy) * ix0 + (ox0 * stride + fx);
        weights_addr_c = (ic1 * fy_b + fy) * fy_b + fx;
        ofmap_addr_c   = oy0 * oy0_b + ox0;
        first_c = (step_cnt[4] == '0) && (step_cnt[3] == '0) && (step_cnt[2] == '0);
        last_c  = &step_max[4:2];
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        tile_adv   = 1'b0;
        unique case (state)
            IDLE: if (accept_c) state_next = WAIT;
            WAIT: begin
                if (bus.ifmap_bank_ready && bus.weights_bank_ready && bus.ofmap_bank_free) begin
                    state_next = RUN;
                    issue      = 1'b1;
                end
            end
            RUN: begin
                if (tile_last_q) begin
                    state_next = TILE_END;
                    tile_adv   = 1'b1;
                end else begin
                    issue = 1'b1;
                end
            end
            TILE_END: state_next = done_q ? IDLE : WAIT;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            prm            <= '0;
            ix0            <= '0;
            ixy            <= '0;
            rdy_q          <= 1'b1;
            err_q          <= 1'b0;
            step_vld_q     <= 1'b0;
            first_q        <= 1'b0;
            last_q         <= 1'b0;
            tile_last_q    <= 1'b0;
            isw_q          <= 1'b0;
            wsw_q          <= 1'b0;
            osw_q          <= 1'b0;
            done_q         <= 1'b0;
            ifmap_addr_q   <= '0;
            weights_addr_q <= '0;
            ofmap_addr_q   <= '0;
        end else begin
            state       <= state_next;
            rdy_q       <= (state_next == IDLE);
            err_q       <= (state == IDLE) && bus.layer_params_vld && rdy_q && bad_c;
            step_vld_q  <= issue;
            first_q     <= issue && first_c;
            last_q      <= issue && last_c;
            tile_last_q <= issue && (&step_max);
            wsw_q       <= tile_adv;
            osw_q       <= tile_adv;
            isw_q       <= tile_adv && tile_max[0];
            done_q      <= tile_adv && (&tile_max);
            if (accept_c) begin
                prm <= prm_in;
                ix0 <= ix0_in;
                ixy <= ixy_in;
            end
            if (issue) begin
                ifmap_addr_q   <= ifmap_addr_c;
                weights_addr_q <= weights_addr_c;
                ofmap_addr_q   <= ofmap_addr_c;
            end
        end
    end

    assign bus.layer_params_rdy = rdy_q;
    assign bus.params_err       = err_q;
    assign bus.step_vld         = step_vld_q;
    assign bus.acc_first        = first_q;
    assign bus.acc_last         = last_q;
    assign bus.ifmap_rd_addr    = ifmap_addr_q;
    assign bus.weights_rd_addr  = weights_addr_q;
    assign bus.ofmap_wr_addr    = ofmap_addr_q;
    assign bus.ifmap_switch     = isw_q;
    assign bus.weights_switch   = wsw_q;
    assign bus.ofmap_switch     = osw_q;
    assign bus.layer_done       = done_q;

`ifdef CONV_LOOP_CTRL_PERF_EN
    logic [PERF_WIDTH-1:0] stall_q, busy_q;

    // Saturating WAIT/RUN cycle counters, cleared per layer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            busy_q  <= '0;
        end else if (accept_c) begin
            stall_q <= '0;
            busy_q  <= '0;
        end else begin
            if (state == WAIT && stall_q != '1) stall_q <= stall_q + PERF_WIDTH'(1);
            if (state == RUN && busy_q != '1)   busy_q  <= busy_q + PERF_WIDTH'(1);
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.busy_cycles  = busy_q;
`endif

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// Self-checking bench for conv_loop_ctrl: table of whole-layer runs with
// hand-computed probes and pulse counts, plus stall, bad-params and reset sequences.
module tb_conv_loop_ctrl;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    conv_loop_ctrl_if bus ();

    conv_loop_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] oy1, oc1, ic1, fy, oy0, stride;
        int          probe;
        logic [31:0] e_if, e_w, e_o;
        logic        e_first, e_last;
        int          e_steps, e_tiles, e_isw, e_tcyc;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] oy1, oc1, ic1, fy, oy0, stride);
        int n = 0;
        while (bus.layer_params_rdy !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("load_rdy", 32'(bus.layer_params_rdy), 32'd1);
        bus.layer_params_dat = {oy1, oc1, ic1, fy, oy0, stride};
        bus.layer_params_vld = 1'b1;
        tick();
        bus.layer_params_vld = 1'b0;
    endtask

    task automatic run_layer(input vec_t v, input int idx);
        int steps = 0, tile0_steps = 0, wsw = 0, osw = 0, isw = 0, done = 0, cyc = 0;
        int sw_cyc0 = 0, sw_cyc1 = 0;
        logic [31:0] p_if = 'x, p_w = 'x, p_o = 'x;
        logic        p_first = 1'bx, p_last = 1'bx;
        load(v.oy1, v.oc1, v.ic1, v.fy, v.oy0, v.stride);
        while (done == 0 && cyc < 20000) begin
            tick();
            cyc++;
            if (bus.step_vld) begin
                if (wsw == 0 && tile0_steps == v.probe) begin
                    p_if    = bus.ifmap_rd_addr;
                    p_w     = bus.weights_rd_addr;
                    p_o     = bus.ofmap_wr_addr;
                    p_first = bus.acc_first;
                    p_last  = bus.acc_last;
                end
                if (wsw == 0) tile0_steps++;
                steps++;
            end
            if (bus.weights_switch) begin
                if (wsw == 0) sw_cyc0 = cyc;
                else if (wsw == 1) sw_cyc1 = cyc;
                wsw++;
            end
            if (bus.ofmap_switch) osw++;
            if (bus.ifmap_switch) isw++;
            if (bus.layer_done) done++;
        end
        chk($sformatf("v%0d_done", idx), done, 1);
        chk($sformatf("v%0d_steps", idx), steps, v.e_steps);
        chk($sformatf("v%0d_wsw", idx), wsw, v.e_tiles);
        chk($sformatf("v%0d_osw", idx), osw, v.e_tiles);
        chk($sformatf("v%0d_isw", idx), isw, v.e_isw);
        chk($sformatf("v%0d_probe_if", idx), p_if, v.e_if);
        chk($sformatf("v%0d_probe_w", idx), p_w, v.e_w);
        chk($sformatf("v%0d_probe_o", idx), p_o, v.e_o);
        chk($sformatf("v%0d_probe_first", idx), 32'(p_first), 32'(v.e_first));
        chk($sformatf("v%0d_probe_last", idx), 32'(p_last), 32'(v.e_last));
        if (v.e_tiles > 1) chk($sformatf("v%0d_tile_cycles", idx), sw_cyc1 - sw_cyc0, v.e_tcyc);
    endtask

    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [95:0] bad_dat [2];
        int bad, n;

        rst_n                  = 1'b0;
        bus.layer_params_vld   = 1'b0;
        bus.layer_params_dat   = '0;
        bus.ifmap_bank_ready   = 1'b1;
        bus.weights_bank_ready = 1'b1;
        bus.ofmap_bank_free    = 1'b1;

        //          oy1 oc1 ic1 fy oy0 st probe  if  w  o  f  l  steps tiles isw tcyc
        vecs[0] = '{4, 4, 2, 3, 3, 1, 0,     0,  0, 0, 1, 0, 10368, 64, 16, 164};
        vecs[1] = '{1, 1, 2, 3, 3, 1, 161,   49, 17, 8, 0, 1, 162,   1,  1,  0};
        vecs[2] = '{1, 2, 1, 3, 2, 2, 11,    14, 2, 3, 0, 0, 72,    2,  1,  38};
        vecs[3] = '{2, 1, 1, 1, 1, 1, 0,     0,  0, 0, 1, 1, 4,     4,  4,  3};
        vecs[4] = '{1, 1, 3, 2, 2, 3, 47,    74, 11, 3, 0, 1, 48,   1,  1,  0};
        vecs[5] = '{1, 1, 2, 3, 3, 1, 81,    25, 9, 0, 0, 0, 162,   1,  1,  0};

        bad_dat[0] = {16'd1, 16'd1, 16'd0, 16'd3, 16'd3, 16'd1};
        bad_dat[1] = {16'd2, 16'd2, 16'd1, 16'd3, 16'd3, 16'd0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(bus.layer_params_rdy), 32'd1);
        chk("rst_step_vld", 32'(bus.step_vld), 32'd0);
        chk("rst_ifmap_addr", bus.ifmap_rd_addr, 32'd0);
        chk("rst_pulses", 32'({bus.layer_done, bus.params_err, bus.weights_switch}), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_layer(vecs[i], i);

        // Rejected params: error pulse, stay ready, no steps
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (bus.layer_params_rdy !== 1'b1 && n < 100) begin
                tick();
                n++;
            end
            bus.layer_params_dat = bad_dat[k];
            bus.layer_params_vld = 1'b1;
            tick();
            bus.layer_params_vld = 1'b0;
            chk($sformatf("err%0d_pulse", k), 32'(bus.params_err), 32'd1);
            chk($sformatf("err%0d_rdy", k), 32'(bus.layer_params_rdy), 32'd1);
            tick();
            chk($sformatf("err%0d_pulse_end", k), 32'(bus.params_err), 32'd0);
            bad = 0;
            repeat (5) begin
                tick();
                if (bus.step_vld || !bus.layer_params_rdy) bad++;
            end
            chk($sformatf("err%0d_idle", k), bad, 0);
        end

        // Weight bank held off for 10 cycles after tile 0
        load(16'd1, 16'd2, 16'd1, 16'd3, 16'd2, 16'd2);
        n = 0;
        while (!bus.weights_switch && n < 200) begin
            tick();
            n++;
        end
        chk("stall_tile0_end", 32'(bus.weights_switch), 32'd1);
        bus.weights_bank_ready = 1'b0;
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.step_vld || bus.weights_switch || bus.ofmap_switch ||
                bus.ifmap_switch || bus.layer_done) bad++;
        end
        chk("stall_quiet", bad, 0);
        bus.weights_bank_ready = 1'b1;
        tick();
        chk("stall_resume_vld", 32'(bus.step_vld), 32'd1);
        chk("stall_resume_if", bus.ifmap_rd_addr, 32'd0);
        chk("stall_resume_w", bus.weights_rd_addr, 32'd0);
        chk("stall_resume_first", 32'(bus.acc_first), 32'd1);
        n = 0;
        while (!bus.layer_done && n < 200) begin
            tick();
            n++;
        end
        chk("stall_layer_done", 32'(bus.layer_done), 32'd1);
`ifdef CONV_LOOP_CTRL_PERF_EN
        chk("perf_stall", bus.stall_cycles, 32'd11);
        chk("perf_busy", bus.busy_cycles, 32'd72);
`endif

        // Asynchronous reset at step 80 of a running layer
        load(16'd4, 16'd4, 16'd2, 16'd3, 16'd3, 16'd1);
        n = 0;
        bad = 0;
        while (bad < 80 && n < 500) begin
            tick();
            n++;
            if (bus.step_vld) bad++;
        end
        chk("mid_reached_step80", bad, 80);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(bus.layer_params_rdy), 32'd1);
        chk("mid_rst_step_vld", 32'(bus.step_vld), 32'd0);
        chk("mid_rst_ifmap_addr", bus.ifmap_rd_addr, 32'd0);
        chk("mid_rst_flags", 32'({bus.acc_first, bus.acc_last, bus.weights_switch}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        load(16'd1, 16'd1, 16'd2, 16'd3, 16'd3, 16'd1);
        tick();
        chk("post_rst_vld", 32'(bus.step_vld), 32'd1);
        chk("post_rst_if", bus.ifmap_rd_addr, 32'd0);
        chk("post_rst_first", 32'(bus.acc_first), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
